// File: rtl/master_spi.sv
// SPI mode-0 master: shifts one byte out on MOSI and in from MISO, optionally chaining bytes under one CS frame.
// Latency: SETUP (HALF) + 16 SCK half-periods (16*HALF) from request to Done_o; a frame-ending byte adds HOLD + GAP (2*HALF).
// Backpressure: Request_i is honoured only while Busy_o=0; requests that arrive while busy are dropped, never queued.
//
// Ports:
//   Clock, Reset             system clock (rising edge) and asynchronous active-low reset
//   Request_i, Last_i        start a byte; Last_i=1 releases CS after it, 0 keeps CS low for another byte
//   DataToSend_i             byte to transmit, MSB first, captured with the request
//   DataReceived_o, Done_o   received byte and its one-cycle completion strobe
//   Busy_o                   transfer in flight, or CS release in progress
//   CS_o, SCK_o, MOSI_o      SPI outputs (CS active low, CPOL=0, CPHA=0)
//   MISO_i                   SPI input, asynchronous to Clock

module master_spi #(
    parameter int CLOCK_HZ = 25_000_000,
    parameter int SCK_HZ   = 1_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Request_i,
    input  logic       Last_i,
    input  logic [7:0] DataToSend_i,
    output logic [7:0] DataReceived_o,
    output logic       Done_o,
    output logic       Busy_o,
    output logic       CS_o,
    output logic       SCK_o,
    output logic       MOSI_o,
    input  logic       MISO_i
);

    // Number of system clocks per SCK half-period (floor division).
    localparam int HALF = CLOCK_HZ / (2 * SCK_HZ);
    localparam int CW   = (HALF < 2) ? 1 : $clog2(HALF);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    if (HALF < 2) begin : g_half_check
        $error("master_spi: CLOCK_HZ/(2*SCK_HZ) must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        CHAIN = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   cnt;         // counts down one half-period
    logic            sck_q;       // registered serial clock
    logic [7:0]      tx_q;        // transmit shifter, bit 7 drives MOSI
    logic [7:0]      rx_q;        // receive shifter, filled from bit 0
    logic [7:0]      rx_out;      // byte presented on DataReceived_o
    logic [2:0]      bit_cnt;     // falling edges seen in this byte
    logic            last_q;      // frame ends after this byte
    logic            done_q;
    logic            miso_s1;
    logic            miso_s2;

    logic            busy;
    logic            accept;
    logic            phase_end;
    logic            sck_rise;
    logic            sck_fall;
    logic            last_fall;

    // ------------------------------------------------------------------
    // Phase timing and edge decode
    // ------------------------------------------------------------------
    assign phase_end = (cnt == '0);
    assign sck_rise  = (state == SHIFT) && phase_end && !sck_q;
    assign sck_fall  = (state == SHIFT) && phase_end &&  sck_q;
    assign last_fall = sck_fall && (bit_cnt == 3'd7);

    // Busy is derived from the FSM; the Done_o cycle still counts as busy so
    // a request coinciding with the completion strobe is dropped, even when
    // the FSM has already moved to CHAIN.
    assign accept = Request_i && !busy;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                if (phase_end) state_next = SHIFT;
            end
            SHIFT: begin
                if (last_fall) state_next = last_q ? HOLD : CHAIN;
            end
            HOLD: begin
                if (phase_end) state_next = GAP;
            end
            CHAIN: begin
                // CS stays asserted here for as long as it takes the next
                // request to arrive.
                if (accept) state_next = SETUP;
            end
            GAP: begin
                if (phase_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        CS_o   = 1'b1;
        MOSI_o = 1'b0;
        busy   = 1'b1;
        case (state)
            IDLE: begin
                CS_o = 1'b1;
                busy = done_q;
            end
            SETUP, SHIFT: begin
                CS_o   = 1'b0;
                MOSI_o = tx_q[7];
            end
            HOLD: begin
                CS_o = 1'b0;
            end
            CHAIN: begin
                CS_o = 1'b0;
                busy = done_q;
            end
            GAP: begin
                CS_o = 1'b1;
            end
            default: begin
                CS_o = 1'b1;
            end
        endcase
    end

    assign Busy_o         = busy;
    assign SCK_o          = sck_q;
    assign Done_o         = done_q;
    assign DataReceived_o = rx_out;

    // ------------------------------------------------------------------
    // MISO synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= MISO_i;
            miso_s2 <= miso_s1;
        end
    end

    // ------------------------------------------------------------------
    // Half-period counter: reloads on every state change and at the end of
    // every phase, so each phase is exactly HALF cycles with no drift.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if ((state_next != state) || phase_end) begin
            cnt <= HALF_M1;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Serial clock: SHIFT starts with a low half-period, then toggles each
    // phase; the 8th falling edge coincides with leaving SHIFT.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sck_q <= 1'b0;
        end else if (sck_rise) begin
            sck_q <= 1'b1;
        end else if (sck_fall) begin
            sck_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Transmit path: capture on request, advance MOSI on falling edges 1..7.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_q    <= 8'h00;
            last_q  <= 1'b0;
            bit_cnt <= 3'd0;
        end else if (accept) begin
            tx_q    <= DataToSend_i;
            last_q  <= Last_i;
            bit_cnt <= 3'd0;
        end else if (sck_fall && (bit_cnt != 3'd7)) begin
            tx_q    <= {tx_q[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Receive path: sample on the cycle SCK rises; publish with Done.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rx_q   <= 8'h00;
            rx_out <= 8'h00;
            done_q <= 1'b0;
        end else begin
            done_q <= last_fall;
            if (sck_rise) begin
                rx_q <= {rx_q[6:0], miso_s2};
            end
            if (last_fall) begin
                rx_out <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_master_spi.sv
module tb_master_spi;

    localparam int CLOCK_HZ = 25_000_000;
    localparam int SCK_HZ   = 2_500_000;

    logic       Clock        = 1'b0;
    logic       Reset        = 1'b0;
    logic       Request_i    = 1'b0;
    logic       Last_i       = 1'b0;
    logic [7:0] DataToSend_i = 8'h00;
    logic [7:0] DataReceived_o;
    logic       Done_o;
    logic       Busy_o;
    logic       CS_o;
    logic       SCK_o;
    logic       MOSI_o;
    logic       MISO_i;

    master_spi #(
        .CLOCK_HZ(CLOCK_HZ),
        .SCK_HZ  (SCK_HZ)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Request_i     (Request_i),
        .Last_i        (Last_i),
        .DataToSend_i  (DataToSend_i),
        .DataReceived_o(DataReceived_o),
        .Done_o        (Done_o),
        .Busy_o        (Busy_o),
        .CS_o          (CS_o),
        .SCK_o         (SCK_o),
        .MOSI_o        (MOSI_o),
        .MISO_i        (MISO_i)
    );

    always #5 Clock = ~Clock;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- slave model and bus monitor ----------------
    int         cyc           = 0;
    int         cs_fall_cyc   = 0;
    int         cs_low_len    = 0;
    int         cs_rise_cnt   = 0;
    int         done_cnt      = 0;
    int         rise_cnt      = 0;
    int         last_rise     = 0;
    int         sck_period    = 0;
    int         sck_high      = 0;
    int         busy_fall_cnt = 0;
    int         s_cnt         = 0;
    int         s_nlog        = 0;
    logic       prev_cs       = 1'b1;
    logic       prev_sck      = 1'b0;
    logic       prev_busy     = 1'b0;
    logic       miso_slave    = 1'b0;
    logic [1:0] miso_mode     = 2'd0;   // 0 slave, 1 stuck high, 2 stuck low
    logic [7:0] s_tx          = 8'h00;
    logic [7:0] s_sh          = 8'h00;
    logic [7:0] s_rx          = 8'h00;
    logic [7:0] s_log [0:31];

    assign MISO_i = (miso_mode == 2'd0) ? miso_slave :
                    (miso_mode == 2'd1) ? 1'b1 : 1'b0;

    always @(negedge Clock) begin
        cyc       <= cyc + 1;
        prev_cs   <= CS_o;
        prev_sck  <= SCK_o;
        prev_busy <= Busy_o;
        if (prev_cs && !CS_o) begin
            cs_fall_cyc <= cyc;
            s_sh        <= s_tx;
            s_cnt       <= 0;
            miso_slave  <= s_tx[7];
        end
        if (!prev_cs && CS_o) begin
            cs_rise_cnt <= cs_rise_cnt + 1;
            cs_low_len  <= cyc - cs_fall_cyc;
        end
        if (!prev_sck && SCK_o) begin
            s_rx       <= {s_rx[6:0], MOSI_o};
            rise_cnt   <= rise_cnt + 1;
            sck_period <= cyc - last_rise;
            last_rise  <= cyc;
            if (s_cnt == 7) begin
                s_log[s_nlog % 32] <= {s_rx[6:0], MOSI_o};
                s_nlog             <= s_nlog + 1;
                s_cnt              <= 0;
            end else begin
                s_cnt <= s_cnt + 1;
            end
        end
        if (prev_sck && !SCK_o) begin
            sck_high <= cyc - last_rise;
            if (s_cnt == 0) begin
                s_sh       <= s_tx;
                miso_slave <= s_tx[7];
            end else begin
                s_sh       <= {s_sh[6:0], 1'b0};
                miso_slave <= s_sh[6];
            end
        end
        if (Done_o) done_cnt <= done_cnt + 1;
        if (prev_busy && !Busy_o) busy_fall_cnt <= busy_fall_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        Request_i    = 1'b1;
        DataToSend_i = d;
        Last_i       = last;
        tick();
        Request_i    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (Done_o) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!Busy_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_idle_seen"}, 32'(got), 32'd1);
    endtask

    function automatic logic [7:0] slave_got(input int back);
        return s_log[(s_nlog - back) % 32];
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        int r0;
        int bf0;
        int c0;

        // Reset state
        repeat (3) tick();
        chk("rst_cs",    32'(CS_o),           32'd1);
        chk("rst_sck",   32'(SCK_o),          32'd0);
        chk("rst_mosi",  32'(MOSI_o),         32'd0);
        chk("rst_busy",  32'(Busy_o),         32'd0);
        chk("rst_done",  32'(Done_o),         32'd0);
        chk("rst_rdata", 32'(DataReceived_o), 32'h00);
        Reset = 1'b1;
        repeat (3) tick();

        // Single byte 0xA5, slave answers 0x3C
        s_tx = 8'h3C;
        d0   = done_cnt;
        send(8'hA5, 1'b1);
        wait_done("a5");
        chk("a5_busy_at_done", 32'(Busy_o),         32'd1);
        chk("a5_rdata",        32'(DataReceived_o), 32'h3C);
        tick();
        chk("a5_done_pulse",   32'(Done_o),         32'd0);
        wait_idle("a5");
        tick();
        chk("a5_slave_rx",     32'(slave_got(1)),   32'hA5);
        chk("a5_cs_low_len",   32'(cs_low_len),     32'd90);
        chk("a5_done_count",   32'(done_cnt - d0),  32'd1);
        chk("a5_cs_high",      32'(CS_o),           32'd1);
        chk("a5_mosi_idle",    32'(MOSI_o),         32'd0);
        chk("a5_sck_period",   32'(sck_period),     32'd10);
        chk("a5_sck_high",     32'(sck_high),       32'd5);

        // Chained 0x12 (keep CS) then 0x34 (end frame); request in the Done cycle is dropped
        s_tx = 8'h5A;
        d0   = done_cnt;
        c0   = cs_rise_cnt;
        send(8'h12, 1'b0);
        wait_done("ch1");
        Request_i    = 1'b1;
        DataToSend_i = 8'h77;
        Last_i       = 1'b1;
        tick();
        Request_i    = 1'b0;
        r0 = rise_cnt;
        tick();
        tick();
        chk("chain_busy",    32'(Busy_o),   32'd0);
        chk("chain_cs",      32'(CS_o),     32'd0);
        chk("chain_no_sck",  32'(rise_cnt - r0), 32'd0);
        send(8'h34, 1'b1);
        wait_done("ch2");
        chk("ch2_rdata",     32'(DataReceived_o), 32'h5A);
        wait_idle("ch2");
        tick();
        chk("chain_cs_rises",  32'(cs_rise_cnt - c0), 32'd1);
        chk("chain_done_cnt",  32'(done_cnt - d0),    32'd2);
        chk("chain_slave_b0",  32'(slave_got(2)),     32'h12);
        chk("chain_slave_b1",  32'(slave_got(1)),     32'h34);

        // Request held high through a whole transfer
        s_tx = 8'h0F;
        d0   = done_cnt;
        bf0  = busy_fall_cnt;
        Request_i    = 1'b1;
        DataToSend_i = 8'hC3;
        Last_i       = 1'b1;
        wait_done("hold");
        chk("hold_busy_cont", 32'(busy_fall_cnt - bf0), 32'd0);
        wait_idle("hold");
        chk("hold_one_xfer",  32'(done_cnt - d0), 32'd1);
        chk("hold_idle_cs",   32'(CS_o),          32'd1);
        tick();
        Request_i = 1'b0;
        chk("hold_restart_busy", 32'(Busy_o), 32'd1);
        chk("hold_restart_cs",   32'(CS_o),   32'd0);
        wait_done("hold2");
        wait_idle("hold2");
        tick();
        chk("hold_slave_rx", 32'(slave_got(1)), 32'hC3);

        // Reset at the 4th SCK rising edge
        d0 = done_cnt;
        r0 = rise_cnt;
        send(8'h81, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt - r0 >= 4) break;
            tick();
        end
        chk("abort_4th_rise", 32'(rise_cnt - r0), 32'd4);
        Reset = 1'b0;
        #1;
        chk("abort_cs",    32'(CS_o),           32'd1);
        chk("abort_sck",   32'(SCK_o),          32'd0);
        chk("abort_busy",  32'(Busy_o),         32'd0);
        chk("abort_rdata", 32'(DataReceived_o), 32'h00);
        repeat (3) tick();
        Reset = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        s_tx = 8'h96;
        send(8'hFF, 1'b1);
        wait_done("after_abort");
        chk("after_abort_rdata", 32'(DataReceived_o), 32'h96);
        wait_idle("after_abort");
        tick();
        chk("after_abort_slave", 32'(slave_got(1)), 32'hFF);

        // MISO stuck high, then stuck low
        miso_mode = 2'd1;
        repeat (3) tick();
        send(8'h00, 1'b1);
        wait_done("stuck1");
        chk("stuck1_rdata", 32'(DataReceived_o), 32'hFF);
        wait_idle("stuck1");
        miso_mode = 2'd2;
        repeat (3) tick();
        send(8'h00, 1'b1);
        wait_done("stuck0");
        chk("stuck0_rdata", 32'(DataReceived_o), 32'h00);
        wait_idle("stuck0");
        tick();
        chk("stuck0_sck_period", 32'(sck_period), 32'd10);
        chk("stuck0_sck_high",   32'(sck_high),   32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
